// File: rtl/weight_mac_cell.sv
// weight_mac_cell: one neuron MAC stage of a systolic chain.
//   clk, rst_n                      clock, asynchronous active-low reset
//   weight_wr_en/addr/data          write one slot of the local weight array
//   input_index/value/enable        activation stream in
//   input_result                    upstream result bus, MSB = valid
//   output_index/value/enable       activation stream, registered pass-through
//   output_result                   result bus to the next cell, MSB = valid
//   overflow                        sticky: a finished local result was dropped
module weight_mac_cell #(
    parameter int DATA_WIDTH    = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int RESULT_WIDTH  = 24,
    parameter int INDEX_WIDTH   = 10,
    parameter int WEIGHT_AMOUNT = 4,
    parameter int INPUT_OFFSET  = 0,
    parameter int WEIGHT_OFFSET = 0,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    weight_wr_en,
    input  logic [INDEX_WIDTH-1:0]  weight_wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] weight_wr_data,
    input  logic [INDEX_WIDTH-1:0]  input_index,
    input  logic [DATA_WIDTH-1:0]   input_value,
    input  logic                    input_enable,
    input  logic [RESULT_WIDTH:0]   input_result,
    output logic [INDEX_WIDTH-1:0]  output_index,
    output logic [DATA_WIDTH-1:0]   output_value,
    output logic                    output_enable,
    output logic [RESULT_WIDTH:0]   output_result,
    output logic                    overflow
);
    localparam int AW = WEIGHT_AMOUNT > 1 ? $clog2(WEIGHT_AMOUNT) : 1;
    localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = RESULT_WIDTH + 2;
    localparam logic [INDEX_WIDTH:0]    NUM_W  = (INDEX_WIDTH+1)'(WEIGHT_AMOUNT);
    localparam logic [INDEX_WIDTH:0]    LAST_W = (INDEX_WIDTH+1)'(WEIGHT_AMOUNT - 1);
    localparam logic [CW-1:0]           FULL   = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0]           LAST_P = FW'(FIFO_DEPTH - 1);
    localparam logic [RESULT_WIDTH-1:0] MAXV   = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic [RESULT_WIDTH-1:0] MINV   = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

    logic [WEIGHT_WIDTH-1:0] r_weight [WEIGHT_AMOUNT];
    logic [RESULT_WIDTH-1:0] r_acc;
    logic [RESULT_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [FW-1:0]           r_rd;
    logic [FW-1:0]           r_wr;
    logic [CW-1:0]           r_cnt;

    logic                    w_in_range;
    logic                    w_last;
    logic [WEIGHT_WIDTH-1:0] w_wsel;
    logic [DATA_WIDTH:0]     w_a_g;
    logic [WEIGHT_WIDTH:0]   w_w_g;
    logic [EW-1:0]           w_a;
    logic [EW-1:0]           w_w;
    logic [EW-1:0]           w_prod;
    logic [EW-1:0]           w_base;
    logic [EW-1:0]           w_sum;
    logic [RESULT_WIDTH-1:0] w_sat;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push_req;
    logic                    w_push;

    // Operands carry one guard bit so offset subtraction cannot wrap; once
    // sign-extended to EW bits, the low EW bits of an unsigned multiply equal
    // the signed product, so no signed types are needed.
    always_comb begin
        w_in_range = {1'b0, input_index} < NUM_W;
        w_last     = {1'b0, input_index} == LAST_W;
        w_wsel     = w_in_range ? r_weight[input_index[AW-1:0]] : '0;
        w_a_g      = {1'b0, input_value} - (DATA_WIDTH+1)'(INPUT_OFFSET);
        w_w_g      = {1'b0, w_wsel} - (WEIGHT_WIDTH+1)'(WEIGHT_OFFSET);
        w_a        = {{(EW-DATA_WIDTH-1){w_a_g[DATA_WIDTH]}}, w_a_g};
        w_w        = {{(EW-WEIGHT_WIDTH-1){w_w_g[WEIGHT_WIDTH]}}, w_w_g};
        w_prod     = w_a * w_w;
        w_base     = input_index == '0 ? '0 : {{2{r_acc[RESULT_WIDTH-1]}}, r_acc};
        w_sum      = w_base + w_prod;
        // In range exactly when the top three bits agree.
        w_sat      = (&w_sum[EW-1:RESULT_WIDTH-1] | ~|w_sum[EW-1:RESULT_WIDTH-1]) ?
                     w_sum[RESULT_WIDTH-1:0] : (w_sum[EW-1] ? MINV : MAXV);
        w_pop      = ~input_result[RESULT_WIDTH] & (r_cnt != '0);
        w_full     = r_cnt == FULL;
        w_push_req = input_enable & w_last;
        // A full queue still accepts a push when the head leaves in the same cycle.
        w_push     = w_push_req & (~w_full | w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WEIGHT_AMOUNT; i++) r_weight[i] <= '0;
        end else if (weight_wr_en && {1'b0, weight_wr_addr} < NUM_W) begin
            r_weight[weight_wr_addr[AW-1:0]] <= weight_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            output_index  <= '0;
            output_value  <= '0;
            output_enable <= 1'b0;
        end else begin
            if (input_enable && w_in_range) r_acc <= w_sat;
            output_index  <= input_enable ? input_index : '0;
            output_value  <= input_enable ? input_value : '0;
            output_enable <= input_enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_cnt         <= '0;
            output_result <= '0;
            overflow      <= 1'b0;
        end else begin
            if (w_push) r_fifo[r_wr] <= w_sat;
            if (w_push) r_wr <= r_wr == LAST_P ? '0 : r_wr + FW'(1);
            if (w_pop) r_rd <= r_rd == LAST_P ? '0 : r_rd + FW'(1);
            r_cnt <= (w_push & ~w_pop) ? r_cnt + CW'(1) :
                     (~w_push & w_pop) ? r_cnt - CW'(1) : r_cnt;
            output_result <= input_result[RESULT_WIDTH] ? input_result :
                             w_pop ? {1'b1, r_fifo[r_rd]} : '0;
            if (w_push_req & w_full & ~w_pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_weight_mac_cell.sv
// tb_weight_mac_cell: directed vector bench for weight_mac_cell across four parameter sets.
module tb_weight_mac_cell;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        we;
    logic [9:0]  wa;
    logic [7:0]  wd;
    logic [9:0]  ix;
    logic [7:0]  iv;
    logic        ie;
    logic [24:0] ir;

    logic [9:0]  oi [4];
    logic [7:0]  ov [4];
    logic        oe [4];
    logic        ovf [4];
    logic [24:0] res0, res1, res3;
    logic [16:0] res2;

    int checks = 0;
    int errors = 0;

    localparam logic [24:0] U = 25'h1123456;
    localparam logic [24:0] V = 25'h1000ABC;

    weight_mac_cell u0 (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(we), .weight_wr_addr(wa), .weight_wr_data(wd),
        .input_index(ix), .input_value(iv), .input_enable(ie), .input_result(ir),
        .output_index(oi[0]), .output_value(ov[0]), .output_enable(oe[0]),
        .output_result(res0), .overflow(ovf[0]));

    weight_mac_cell #(.INPUT_OFFSET(128), .WEIGHT_OFFSET(128)) u1 (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(we), .weight_wr_addr(wa), .weight_wr_data(wd),
        .input_index(ix), .input_value(iv), .input_enable(ie), .input_result(ir),
        .output_index(oi[1]), .output_value(ov[1]), .output_enable(oe[1]),
        .output_result(res1), .overflow(ovf[1]));

    weight_mac_cell #(.RESULT_WIDTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(we), .weight_wr_addr(wa), .weight_wr_data(wd),
        .input_index(ix), .input_value(iv), .input_enable(ie), .input_result(17'd0),
        .output_index(oi[2]), .output_value(ov[2]), .output_enable(oe[2]),
        .output_result(res2), .overflow(ovf[2]));

    weight_mac_cell #(.FIFO_DEPTH(1)) u3 (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(we), .weight_wr_addr(wa), .weight_wr_data(wd),
        .input_index(ix), .input_value(iv), .input_enable(ie), .input_result(ir),
        .output_index(oi[3]), .output_value(ov[3]), .output_enable(oe[3]),
        .output_result(res3), .overflow(ovf[3]));

    typedef struct {
        logic        we;
        logic [9:0]  wa;
        logic [7:0]  wd;
        logic [9:0]  ix;
        logic [7:0]  v;
        logic        e;
        logic [24:0] ir;
        logic [24:0] res;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic w, logic [9:0] a, logic [7:0] d, logic [9:0] i,
                                logic [7:0] v, logic e, logic [24:0] r, logic [24:0] x);
        mk = '{w, a, d, i, v, e, r, x};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [7:0] d,
                         input logic [9:0] i, input logic [7:0] v, input logic e,
                         input logic [24:0] r);
        we = w; wa = a; wd = d; ix = i; iv = v; ie = e; ir = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neuron(input logic [7:0] v, input logic [24:0] r);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 10'(i), v, 1, r);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.res0", res0, 0);
        chk("rst.en0", oe[0], 0);
        chk("rst.ovf3", ovf[3], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        tv.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 2, 3, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 3, 4, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 7, 99, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 2, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5, 9, 0, 0, 25'h100000A));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 2, 2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3, 2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, U, U));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 25'h1000014));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 10, 0, 3, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 25'h1000003));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 9, 7, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 2, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 25'h1000013));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tv[k]) begin
            drive(tv[k].we, tv[k].wa, tv[k].wd, tv[k].ix, tv[k].v, tv[k].e, tv[k].ir);
            tick();
            chk($sformatf("vec%0d.res", k), res0, tv[k].res);
            chk($sformatf("vec%0d.en", k), oe[0], tv[k].e);
            chk($sformatf("vec%0d.idx", k), oi[0], tv[k].e ? tv[k].ix : 10'd0);
            chk($sformatf("vec%0d.val", k), ov[0], tv[k].e ? tv[k].v : 8'd0);
        end
        chk("table.ovf0", ovf[0], 0);

        for (int i = 0; i < 4; i++) begin
            drive(1, 10'(i), 255, 0, 0, 0, 0);
            tick();
        end
        neuron(0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("offs.neg", res1, 25'h1FF0200);
        tick();
        chk("offs.idle", res1, 0);
        neuron(255, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("sat16.res", res2, 17'h17FFF);
        chk("sat16.ovf", ovf[2], 0);
        chk("offs.pos", res1, 25'h100FC04);
        chk("big.res0", res0, 25'h103F804);
        tick();

        neuron(1, V);
        chk("pp.up", res3, V);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 10'(i), 2, 1, V);
            tick();
            chk($sformatf("pp.hold%0d", i), res3, V);
        end
        drive(0, 0, 0, 3, 2, 1, 0);
        tick();
        chk("pp.first", res3, 25'h10003FC);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("pp.second", res3, 25'h10007F8);
        tick();
        chk("pp.empty", res3, 0);
        chk("pp.ovf", ovf[3], 0);

        neuron(1, V);
        neuron(2, V);
        chk("drop.up", res3, V);
        chk("drop.ovf", ovf[3], 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("drop.first", res3, 25'h10003FC);
        chk("deep.first", res0, 25'h10003FC);
        tick();
        chk("drop.once", res3, 0);
        chk("drop.sticky", ovf[3], 1);
        chk("deep.second", res0, 25'h10007F8);
        chk("deep.ovf", ovf[0], 0);
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 10'(i), 1, 1, 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("arst.en", oe[0], 0);
        chk("arst.idx", oi[0], 0);
        chk("arst.res", res0, 0);
        chk("arst.ovf3", ovf[3], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 3, 1, 1, 0);
        tick();
        chk("post.en", oe[0], 1);
        chk("post.idx", oi[0], 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post.data", res0[23:0], 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
